// File: rtl/pipeline_pkg.sv
// Shared constants for the ID/EX pipeline slice: default widths, control-bundle
// bit positions and the stage state encoding.
package pipeline_pkg;

  localparam int WIDTH_B_DEF = 32;
  localparam int ADDR_B_DEF  = 5;
  localparam int CTRL_W      = 8;

  // id_ctrl = {ALUOp[1:0], ALUSrc, RegDst, MemtoReg, MemWrite, MemRead, RegWrite}
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_HI = 7;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } stage_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction currently in decode.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int Addr_B = ADDR_B_DEF
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [Addr_B-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [Addr_B-1:0] id_rs,
  input  logic [Addr_B-1:0] id_rt,
  output logic              hazard
);

  assign hazard = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through bypass, load-use stall insertion,
// flush handling and saturating bubble/flush event counters.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int width_B = WIDTH_B_DEF,
  parameter int Addr_B  = ADDR_B_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [Addr_B-1:0]  id_rs,
  input  logic [Addr_B-1:0]  id_rt,
  input  logic [Addr_B-1:0]  id_rd,
  input  logic [width_B-1:0] id_rs_data,
  input  logic [width_B-1:0] id_rt_data,
  input  logic [width_B-1:0] id_imm,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic               wb_RegWrite,
  input  logic [Addr_B-1:0]  wb_Write_Addr,
  input  logic [width_B-1:0] wb_Write_Data,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic [Addr_B-1:0]  ex_rs,
  output logic [Addr_B-1:0]  ex_rt,
  output logic [Addr_B-1:0]  ex_rd,
  output logic [width_B-1:0] ex_rs_data,
  output logic [width_B-1:0] ex_rt_data,
  output logic [width_B-1:0] ex_imm,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic [15:0]        bubble_count,
  output logic [15:0]        flush_count
);

  stage_state_e       state, state_next;
  logic               hazard;
  logic               load_bubble;
  logic [width_B-1:0] rs_fwd, rt_fwd;

  hazard_detect #(.Addr_B(Addr_B)) u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard      (hazard)
  );

  // Only one stall per hazard: the BUBBLE state lets the held instruction through.
  always_comb begin
    stall      = 1'b0;
    state_next = ST_RUN;
    if (hazard && !flush && state == ST_RUN) begin
      stall      = 1'b1;
      state_next = ST_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Register 0 is hard-wired, so a write to it must never be forwarded.
  always_comb begin
    rs_fwd = id_rs_data;
    rt_fwd = id_rt_data;
    if (wb_RegWrite && wb_Write_Addr == id_rs && id_rs != '0) rs_fwd = wb_Write_Data;
    if (wb_RegWrite && wb_Write_Addr == id_rt && id_rt != '0) rt_fwd = wb_Write_Data;
  end

  assign load_bubble = flush | stall | ~id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else if (load_bubble) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else begin
      ex_valid   <= 1'b1;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= rs_fwd;
      ex_rt_data <= rt_fwd;
      ex_imm     <= id_imm;
      ex_ctrl    <= id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (stall)              bubble_count <= sat_inc16(bubble_count);
      if (flush && id_valid)  flush_count  <= sat_inc16(flush_count);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver predicts each cycle's stall and
// EX contents from the pipeline rules, a monitor compares against the DUT.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [7:0]  ctrl;
  } ex_t;

  typedef struct packed {
    ex_t         ex;
    logic [15:0] bc;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [7:0]  id_ctrl = '0;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_Write_Addr = '0;
  logic [31:0] wb_Write_Data = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_count, flush_count;

  id_ex_stage #(.width_B(32), .Addr_B(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_RegWrite(wb_RegWrite), .wb_Write_Addr(wb_Write_Addr), .wb_Write_Data(wb_Write_Data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t ex_q[$];
  logic stall_q[$];

  // Reference model: what EX should hold, whether the last edge stalled, event totals.
  ex_t         m_ex = '0;
  logic        m_stalled = 1'b0;
  int unsigned m_bc = 0, m_fc = 0;
  logic        last_stall = 1'b0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(
    input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
    input logic [7:0] ctrl, input logic wbw, input logic [4:0] wba,
    input logic [31:0] wbd, input logic fl);
    logic hz, exp_stall;
    ex_t  nx;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl;
    wb_RegWrite = wbw; wb_Write_Addr = wba; wb_Write_Data = wbd; flush = fl;
    #1;
    hz = m_ex.valid && m_ex.ctrl[1] && (m_ex.rt != 0) && v && (m_ex.rt == rs || m_ex.rt == rt);
    exp_stall = hz && !fl && !m_stalled;
    stall_q.push_back(exp_stall);
    nx = '0;
    if (!(fl || exp_stall || !v)) begin
      nx.valid   = 1'b1;
      nx.rs      = rs;
      nx.rt      = rt;
      nx.rd      = rd;
      nx.rs_data = (wbw && wba == rs && rs != 0) ? wbd : rsd;
      nx.rt_data = (wbw && wba == rt && rt != 0) ? wbd : rtd;
      nx.imm     = imm;
      nx.ctrl    = ctrl;
    end
    if (exp_stall && m_bc < 65535) m_bc++;
    if (fl && v && m_fc < 65535) m_fc++;
    m_stalled  = exp_stall;
    m_ex       = nx;
    last_stall = exp_stall;
    ex_q.push_back({nx, 16'(m_bc), 16'(m_fc)});
  endtask

  // Monitor: stall is checked mid-cycle, EX contents just after each rising edge.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) begin
        s = stall_q.pop_front();
        check_output("stall", {127'd0, stall}, {127'd0, s});
      end
      @(posedge clk);
      #1;
      if (ex_q.size() > 0) begin
        e = ex_q.pop_front();
        check_output("ex_bundle",
          {8'd0, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_ctrl},
          {8'd0, e.ex});
        check_output("bubble_count", {112'd0, bubble_count}, {112'd0, e.bc});
        check_output("flush_count",  {112'd0, flush_count},  {112'd0, e.fc});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0]  r_rs, r_rt, r_rd;
    logic [31:0] r_rsd, r_rtd, r_imm;
    logic [7:0]  r_ctrl;
    logic        r_v;

    // Reset values while rst_n is held low.
    #12;
    check_output("reset_ex",
      {8'd0, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_ctrl}, 128'd0);
    check_output("reset_counts", {96'd0, bubble_count, flush_count}, 128'd0);
    check_output("reset_stall", {127'd0, stall}, 128'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Plain pass-through.
    apply_stimulus(1, 3, 0, 2, 5, 0, 0, 8'h01, 0, 0, 0, 0);
    // Bypass on rs, then the same with address 0 which must not bypass.
    apply_stimulus(1, 4, 1, 2, 6, 8, 0, 8'h01, 1, 4, 99, 0);
    apply_stimulus(1, 0, 1, 2, 6, 8, 0, 8'h01, 1, 0, 99, 0);
    // Load-use: lw to r7, then consumer of r7 stalls once and enters one cycle later.
    apply_stimulus(1, 1, 7, 0, 10, 20, 4, 8'h0B, 0, 0, 0, 0);
    apply_stimulus(1, 7, 2, 3, 30, 40, 0, 8'h01, 0, 0, 0, 0);
    apply_stimulus(1, 7, 2, 3, 30, 40, 0, 8'h01, 1, 7, 77, 0);
    // Flush during hazard: no stall, bubble, flush counted.
    apply_stimulus(1, 1, 7, 0, 10, 20, 4, 8'h0B, 0, 0, 0, 0);
    apply_stimulus(1, 7, 2, 3, 30, 40, 0, 8'h01, 0, 0, 0, 1);
    apply_stimulus(0, 7, 7, 3, 1, 2, 3, 8'h03, 0, 0, 0, 0);

    // Randomized traffic; a stalled instruction is re-presented by decode.
    r_v = 0; r_rs = 0; r_rt = 0; r_rd = 0; r_rsd = 0; r_rtd = 0; r_imm = 0; r_ctrl = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        r_v    = ($urandom_range(0, 99) < 85);
        r_rs   = 5'($urandom_range(0, 7));
        r_rt   = 5'($urandom_range(0, 7));
        r_rd   = 5'($urandom_range(0, 31));
        r_rsd  = $urandom;
        r_rtd  = $urandom;
        r_imm  = $urandom;
        r_ctrl = 8'($urandom);
      end
      apply_stimulus(r_v, r_rs, r_rt, r_rd, r_rsd, r_rtd, r_imm, r_ctrl,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                     ($urandom_range(0, 99) < 10));
    end

    // Saturation: preload 16'hFFFE, then chain of r7 loads stalls repeatedly.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    force dut.bubble_count = 16'hFFFE;
    #1;
    release dut.bubble_count;
    m_bc = 65534;
    for (int i = 0; i < 7; i++)
      apply_stimulus(1, 7, 7, 1, 5, 6, 0, 8'h03, 0, 0, 0, 0);

    for (int i = 0; i < 10 && (ex_q.size() > 0 || stall_q.size() > 0); i++) @(posedge clk);
    check_output("queue_drain", {96'd0, 32'(ex_q.size() + stall_q.size())}, 128'd0);

    // Asynchronous reset between edges while EX holds a valid instruction.
    apply_stimulus(1, 2, 3, 4, 11, 12, 13, 8'h01, 0, 0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_valid", {127'd0, ex_valid}, 128'd0);
    check_output("async_reset_counts", {96'd0, bubble_count, flush_count}, 128'd0);
    check_output("async_reset_stall", {127'd0, stall}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
